// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
//  Shared constants and types for the ram_fifo controller.
//  The DEF_* values are the default build configuration; DEPTH, CNT_WIDTH
//  and ptr_t describe that default build (RAM depth, occupancy width and
//  RAM pointer type).
package ram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH      = 5;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_ALMOST_FULL_LVL = 28;

    localparam int DEPTH     = 2 ** DEF_ADDR_WIDTH;
    localparam int CNT_WIDTH = DEF_ADDR_WIDTH + 1;

    typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram
//  Simple dual-port storage: one write port, one read port with a
//  registered output. dout only changes on an edge where read_en is high,
//  so it can serve as the FIFO head slot.
// Ports:
//  clk       in   clock, all logic posedge
//  write_en  in   write strobe
//  waddr     in   write address
//  din       in   write data
//  read_en   in   read strobe; dout loads mem[raddr] at the next edge
//  raddr     in   read address
//  dout      out  registered read data (held while read_en is low)
module dual_port_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (read_en) begin
            dout <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/ram_fifo.sv
// ram_fifo
//  Synchronous FIFO controller around a dual_port_ram with a registered
//  read. The RAM output register acts as the head slot, so capacity is
//  2**ADDR_WIDTH + 1 words. Push side is valid/ready, pop side is
//  first-word-fall-through.
//  Optional feature: define RAM_FIFO_WATERMARK_EN to enable the registered
//  almost_full watermark flag; otherwise almost_full is tied to 0.
// Ports:
//  clk          in   clock, all logic posedge
//  sync_reset   in   synchronous active-high reset
//  push         in   write request
//  push_data    in   write word
//  push_ready   out  registered; a push this cycle is accepted
//  pop_valid    out  registered; pop_data holds the head word
//  pop_data     out  head word (RAM dout)
//  pop          in   consume head when pop_valid
//  count        out  total occupancy (RAM + head)
//  overflow     out  sticky: push while !push_ready
//  underflow    out  sticky: pop while !pop_valid
//  almost_full  out  watermark flag (count >= ALMOST_FULL_LVL)
module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ALMOST_FULL_LVL = DEF_ALMOST_FULL_LVL
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  almost_full
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W     = ADDR_WIDTH + 1;

    // A watermark above the maximum occupancy could never fire.
    if (ALMOST_FULL_LVL > RAM_DEPTH + 1) begin : g_bad_lvl
        $error("ram_fifo: ALMOST_FULL_LVL exceeds FIFO capacity");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  push_ready_q, push_ready_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  accept;
    logic                  rd_go;

    // ram_cnt counts only words sitting in the RAM, so a read is never issued
    // to the address being written in the same cycle.
    always_comb begin
        accept       = push & push_ready_q;
        rd_go        = (ram_cnt_q != '0) & (~pop_valid_q | pop);
        wr_ptr_d     = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = rd_go ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_cnt_d    = ram_cnt_q + CNT_W'(accept) - CNT_W'(rd_go);
        pop_valid_d  = rd_go ? 1'b1 : (pop ? 1'b0 : pop_valid_q);
        // push_ready looks only at registered state and next RAM count, so
        // a pop never frees space combinationally in the same cycle.
        push_ready_d = (ram_cnt_d != CNT_W'(RAM_DEPTH));
        count_d      = ram_cnt_d + CNT_W'(pop_valid_d);
        overflow_d   = overflow_q | (push & ~push_ready_q);
        underflow_d  = underflow_q | (pop & ~pop_valid_q);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            count_q      <= '0;
            pop_valid_q  <= 1'b0;
            push_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            count_q      <= count_d;
            pop_valid_q  <= pop_valid_d;
            push_ready_q <= push_ready_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef RAM_FIFO_WATERMARK_EN
    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (32'(count_d) >= 32'(ALMOST_FULL_LVL));
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`else
    assign almost_full = 1'b0;
`endif

    dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk      (clk),
        .write_en (accept),
        .waddr    (wr_ptr_q),
        .din      (push_data),
        .read_en  (rd_go),
        .raddr    (rd_ptr_q),
        .dout     (pop_data)
    );

    assign push_ready = push_ready_q;
    assign pop_valid  = pop_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo
//  Scoreboard bench for ram_fifo (default parameters). Accepted pushes are
//  queued; every pop compares pop_data with the queue head, and occupancy
//  is compared with the queue size after each edge.
module tb_ram_fifo;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        push;
    logic [31:0] push_data;
    logic        push_ready;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        pop;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;
    logic        almost_full;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    ram_fifo dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .push        (push),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .pop         (pop),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .almost_full (almost_full)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: handshakes are decided from outputs sampled #1 after
    // the previous edge, then the edge is taken and state is checked.
    task automatic cycle(input logic p, input logic [31:0] d, input logic q);
        logic [31:0] exp_word;
        logic        exp_af;
        push      = p;
        push_data = d;
        pop       = q;
        if (q && pop_valid && sb.size() > 0) begin
            exp_word = sb.pop_front();
            check("pop_data", pop_data, exp_word);
            n_pops++;
        end
        if (p && push_ready) begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check("count", count, sb.size());
        if (sb.size() == 0) begin
            check("pop_valid_empty", pop_valid, 0);
        end
        if (sb.size() != 32) begin
            check("push_ready_lvl", push_ready, sb.size() != 33);
        end
`ifdef RAM_FIFO_WATERMARK_EN
        exp_af = (sb.size() >= 28);
`else
        exp_af = 1'b0;
`endif
        check("almost_full", almost_full, exp_af);
    endtask

    task automatic do_reset(input logic p, input logic q);
        sync_reset = 1'b1;
        push       = p;
        pop        = q;
        push_data  = $urandom;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        sb.delete();
        check("rst_count", count, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_push_ready", push_ready, 1);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        check("rst_almost_full", almost_full, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() > 0; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
        end
        check("drain_empty", sb.size(), 0);
        check("drain_count", count, 0);
    endtask

    initial begin
        sync_reset = 1'b1;
        push       = 1'b0;
        pop        = 1'b0;
        push_data  = '0;
        do_reset(1'b0, 1'b0);

        // First-word latency: visible two edges after the push.
        cycle(1'b1, 32'hA5A5_0001, 1'b0);
        check("lat_pv_n1", pop_valid, 0);
        cycle(1'b0, 32'h0, 1'b0);
        check("lat_pv_n2", pop_valid, 1);
        check("lat_data", pop_data, 32'hA5A5_0001);
        check("lat_count", count, 1);
        drain();

        // Fill to 33 words, then an overflowing push.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 33; i++) begin
            cycle(1'b1, i, 1'b0);
            if (i == 31) check("ready_at_32", push_ready, 1);
        end
        check("ready_full", push_ready, 0);
        check("count_full", count, 33);
        check("ovf_before", overflow, 0);
        cycle(1'b1, 32'd33, 1'b0);
        check("ovf_set", overflow, 1);
        check("count_after_ovf", count, 33);
        drain();
        check("udf_after_drain", underflow, 0);

        // Full FIFO with push+pop: the first push is refused, order kept.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 33; i++) cycle(1'b1, 32'h100 + i, 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 32'h1000 + i, 1'b1);
            if (i == 0) check("full_pp_ovf", overflow, 1);
        end
        drain();

        // Streaming across three pointer wraps at one word per cycle.
        do_reset(1'b0, 1'b0);
        n_pops = 0;
        for (int i = 0; i < 110; i++) cycle(1'b1, 32'hBEEF_0000 + i, 1'b1);
        check("stream_pops", n_pops, 108);
        check("stream_count", count, 2);
        drain();

        // Pop on empty.
        do_reset(1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        check("udf_set", underflow, 1);
        check("udf_pop_valid", pop_valid, 0);
        check("udf_count", count, 0);

        // Reset dominates push/pop with ten words stored.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h2000 + i, 1'b0);
        check("pre_rst_count", count, 10);
        do_reset(1'b1, 1'b1);

        // Watermark sweep up to full and back.
        for (int i = 0; i < 33; i++) cycle(1'b1, 32'h3000 + i, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
